// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder used as the serial datapath cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: A+B+cin over WIDTH cycles, LSB first, one full-adder cell.
// SERIAL_ADDER_SIGNED_OVF_EN selects two's-complement overflow instead of unsigned carry-out.
//
// state | meaning
// IDLE  | waiting for start; Sum/Overflow hold last result
// RUN   | one bit pair added per edge, counter tracks bit index
// DONE  | result loaded; done pulses in the following cycle as IDLE resumes
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic             ovf_nxt;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_nxt = fa_s;
        end else begin : g_res_wn
            assign res_nxt = {fa_s, res_sh[WIDTH-1:1]};
        end
    endgenerate

    // On the last bit, carry holds the carry into the MSB and fa_co the carry out of it.
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
    assign ovf_nxt = carry ^ fa_co;
`else
    assign ovf_nxt = fa_co;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            Sum      <= '0;
            Overflow <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        carry  <= cin;
                        cnt    <= '0;
                        res_sh <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    res_sh <= res_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        Sum      <= res_nxt;
                        Overflow <= ovf_nxt;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // Registered pulse lands in the cycle after DONE, WIDTH+1 edges after accept.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances against an arithmetic model.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, ov8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;
    logic       busy1, done1, ov1;
    logic [0:0] sum1;

    int ncomp = 0;
    int nfail = 0;

    logic [31:0] last_s8 = '0;
    logic [31:0] last_s1 = '0;
    logic        last_o8 = 1'b0;
    logic        last_o1 = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .cin(cin8),
        .busy(busy8), .done(done8), .Sum(sum8), .Overflow(ov8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .A(a1), .B(b1), .cin(cin1),
        .busy(busy1), .done(done1), .Sum(sum1), .Overflow(ov1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] msk(input int w);
        return 32'((longint'(1) << w) - 1);
    endfunction

    function automatic logic [31:0] m_sum(input int w, input logic [31:0] a, input logic [31:0] b, input logic c);
        longint t;
        t = longint'(a & msk(w)) + longint'(b & msk(w)) + longint'(c);
        return 32'(t) & msk(w);
    endfunction

    function automatic logic m_ovf(input int w, input logic [31:0] a, input logic [31:0] b, input logic c);
        longint ua, ub, half, sa, sb, s;
        ua   = longint'(a & msk(w));
        ub   = longint'(b & msk(w));
        half = longint'(1) << (w - 1);
`ifdef SERIAL_ADDER_SIGNED_OVF_EN
        sa = (ua >= half) ? ua - 2 * half : ua;
        sb = (ub >= half) ? ub - 2 * half : ub;
        s  = sa + sb + longint'(c);
        return (s < -half) || (s >= half);
`else
        sa = 0;
        sb = 0;
        s  = ua + ub + longint'(c);
        return (s >> w) != 0;
`endif
    endfunction

    task automatic drive(input bit w1, input logic st, input logic [31:0] a, input logic [31:0] b, input logic c);
        if (w1) begin
            start1 = st; a1 = a[0:0]; b1 = b[0:0]; cin1 = c;
        end else begin
            start8 = st; a8 = a[7:0]; b8 = b[7:0]; cin8 = c;
        end
    endtask

    function automatic logic [31:0] o_sum(input bit w1);
        return w1 ? {31'b0, sum1} : {24'b0, sum8};
    endfunction
    function automatic logic o_ovf(input bit w1);
        return w1 ? ov1 : ov8;
    endfunction
    function automatic logic o_busy(input bit w1);
        return w1 ? busy1 : busy8;
    endfunction
    function automatic logic o_done(input bit w1);
        return w1 ? done1 : done8;
    endfunction

    // Called at a negedge; start is accepted on the very next posedge (edge 0).
    task automatic do_op(input bit w1, input logic [31:0] a, input logic [31:0] b, input logic c, input bit glitch);
        int          w;
        int          n;
        bit          seen;
        logic [31:0] es, ls;
        logic        eo, lo;
        w    = w1 ? 1 : 8;
        n    = -1;
        seen = 0;
        es   = m_sum(w, a, b, c);
        eo   = m_ovf(w, a, b, c);
        ls   = w1 ? last_s1 : last_s8;
        lo   = w1 ? last_o1 : last_o8;
        drive(w1, 1'b1, a, b, c);
        while (!seen && n < w + 6) begin
            @(negedge clk);
            n++;
            if (n == 0)
                drive(w1, glitch, glitch ? 32'hFF : $urandom, glitch ? 32'hFF : $urandom, glitch ? 1'b1 : 1'($urandom));
            else if (n == 1)
                drive(w1, 1'b0, $urandom, $urandom, 1'($urandom));
            if (o_done(w1)) begin
                seen = 1;
            end else begin
                if (n <= w) chk("busy_run", o_busy(w1), 1);
                if (n < w) begin
                    chk("sum_stable", o_sum(w1), ls);
                    chk("ovf_stable", o_ovf(w1), lo);
                end
            end
        end
        chk("latency", n, w + 1);
        chk("sum", o_sum(w1), es);
        chk("ovf", o_ovf(w1), eo);
        chk("busy_at_done", o_busy(w1), 0);
        @(negedge clk);
        chk("done_one_cycle", o_done(w1), 0);
        if (w1) begin last_s1 = es; last_o1 = eo; end
        else begin last_s8 = es; last_o8 = eo; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          cnt;
        int          d1, d2;
        logic [31:0] ra, rb, es;
        logic        rc, eo;

        #1;
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_ovf8", ov8, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_sum1", sum1, 0);
        @(negedge clk);
        reset = 1'b0;

        do_op(0, 32'h0F, 32'h01, 1'b0, 0);
        do_op(0, 32'hFF, 32'h01, 1'b0, 0);
        do_op(0, 32'h7F, 32'h00, 1'b1, 0);

        // start re-pulsed with FF/FF during RUN must be ignored
        do_op(0, 32'h10, 32'h20, 1'b0, 1);
        chk("glitch_sum", sum8, 32'h30);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) cnt++;
        end
        chk("glitch_single_done", cnt, 0);

        // reset during the 4th RUN cycle
        drive(0, 1'b1, 32'h55, 32'hAA, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 32'h00, 32'h00, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_sum", sum8, 0);
        chk("abort_ovf", ov8, 0);
        last_s8 = '0; last_o8 = 1'b0; last_s1 = '0; last_o1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        do_op(0, 32'h01, 32'h01, 1'b0, 0);
        chk("after_abort_sum", sum8, 32'h02);

        // start accepted on the first edge after reset release
        reset = 1'b1;
        last_s8 = '0; last_o8 = 1'b0; last_s1 = '0; last_o1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_op(0, 32'hC3, 32'h5A, 1'b1, 0);

        // start held high: back-to-back results every WIDTH+2 cycles
        ra = $urandom; rb = $urandom; rc = 1'($urandom);
        es = m_sum(8, ra, rb, rc);
        eo = m_ovf(8, ra, rb, rc);
        drive(0, 1'b1, ra, rb, rc);
        d1 = 0; d2 = 0; cnt = 0;
        for (int n = 0; n <= 31; n++) begin
            @(negedge clk);
            if (n == 20) drive(0, 1'b0, ra, rb, rc);
            if (done8) begin
                cnt++;
                if (d1 == 0) d1 = n;
                else if (d2 == 0) d2 = n;
                chk("b2b_sum", sum8, es);
                chk("b2b_ovf", ov8, eo);
            end
        end
        chk("b2b_first", d1, 9);
        chk("b2b_period", d2 - d1, 10);
        chk("b2b_count", cnt, 3);
        last_s8 = es; last_o8 = eo;

        for (int i = 0; i < 20; i++)
            do_op(0, $urandom, $urandom, 1'($urandom), 0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            do_op(1, {31'b0, v[2]}, {31'b0, v[1]}, v[0], 0);
            chk("w1_xor", sum1, {31'b0, v[2] ^ v[1] ^ v[0]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit, single clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin an addition, sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH bits, operand A, captured on the accepted start edge.
REQ-006 SHALL have port B, input, WIDTH bits, operand B, captured on the accepted start edge.
REQ-007 SHALL have port cin, input, 1 bit, carry-in, captured on the accepted start edge.
REQ-008 SHALL have port busy, output, 1 bit, high whenever state is not IDLE.
REQ-009 SHALL have port done, output, 1 bit, one-cycle pulse when Sum and Overflow are valid.
REQ-010 SHALL have port Sum, output, WIDTH bits, result A+B+cin modulo 2^WIDTH.
REQ-011 SHALL have port Overflow, output, 1 bit, overflow flag per REQ-027.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE: on a clk edge with start=1, SHALL capture A, B and cin into shift and carry registers, clear the bit counter, and go to RUN.
REQ-014 IDLE: with start=0, SHALL remain in IDLE, with Sum and Overflow holding their last values.
REQ-015 RUN: each edge SHALL add one bit pair, LSB first, through the full-adder cell with the carry register.
- sum bit shifted into the MSB of the result register
- carry register updated
- counter incremented
REQ-016 RUN: on the edge that processes bit WIDTH-1, SHALL load Sum and Overflow and go to DONE.
REQ-017 DONE: SHALL assert done for exactly one cycle, then return to IDLE unconditionally.
REQ-018 Latency: done SHALL be high in the cycle beginning WIDTH+1 edges after the accepting start edge.
REQ-019 start SHALL be ignored in RUN and DONE; operands and carry-in SHALL NOT be re-captured.
REQ-020 Sum and Overflow SHALL change only on the DONE-entry edge, and SHALL be stable otherwise.
REQ-021 Carry wrap-around: carry out of bit WIDTH-1 SHALL be discarded from Sum (modulo result).
REQ-022 start held high continuously SHALL begin a new operation on each IDLE edge, giving back-to-back results every WIDTH+2 cycles.
REQ-023 Counter width SHALL be $clog2(WIDTH+1), with no wrap inside an operation.

Reset
REQ-024 reset=1 SHALL asynchronously force:
- state to IDLE
- busy=0, done=0, Sum=0, Overflow=0
- counter, carry register and shift registers to 0
REQ-025 reset asserted mid-RUN SHALL abort the operation without producing a done pulse; the first start after reset release SHALL behave as from power-up.
REQ-026 After reset is released, start SHALL be accepted on the first clk edge.

Configuration
REQ-027 Macro SERIAL_ADDER_SIGNED_OVF_EN:
- defined: Overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1 (two's-complement overflow).
- undefined: Overflow = carry out of bit WIDTH-1 (unsigned carry).
REQ-028 The macro SHALL change only the Overflow computation; latency and ports SHALL be identical in both builds.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default width constant (8).
REQ-030 The 1-bit combinational full adder SHALL be a sub-module named full_adder (inputs a, b, ci; outputs s, co), instantiated once.

Verification
REQ-031 WIDTH=8, A=0x0F, B=0x01, cin=0 -> done at edge 9 after start; Sum=0x10, Overflow=0 in both builds.
REQ-032 WIDTH=8, A=0xFF, B=0x01, cin=0 -> Sum=0x00; Overflow=1 unsigned build, 0 signed build.
REQ-033 WIDTH=8, A=0x7F, B=0x00, cin=1 -> Sum=0x80; Overflow=0 unsigned build, 1 signed build.
REQ-034 WIDTH=8, start A=0x55, B=0xAA; reset pulsed during the 4th RUN cycle -> no done, all outputs 0; a new start with A=0x01, B=0x01 -> Sum=0x02.
REQ-035 WIDTH=8, start A=0x10, B=0x20, then start re-pulsed with A=0xFF, B=0xFF during RUN -> single done, Sum=0x30.
REQ-036 WIDTH=1, all 8 combinations of A, B, cin -> Sum = A^B^cin; unsigned-build Overflow = majority(A, B, cin); done 2 edges after each start.
